// File: rtl/hub75_bcm_scan.sv
// HUB75 row scanner with binary-code modulation over COLOR_BITS bit-planes.
// Frame-memory read data is sampled on the clk edge one cycle after the address is driven.
module hub75_bcm_scan #(
    parameter int COLS         = 64,
    parameter int ROW_BITS     = 5,
    parameter int COLOR_BITS   = 4,
    parameter int CLK_DIV      = 1,
    parameter int BLANK_CYCLES = 2,
    parameter int BASE_ON      = 8,
    localparam int CB          = $clog2(COLS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    output logic [ROW_BITS-1:0]     rd_row,
    output logic [CB-1:0]           rd_col,
    input  logic [3*COLOR_BITS-1:0] rd_rgb0,
    input  logic [3*COLOR_BITS-1:0] rd_rgb1,
    output logic                    h75_r1,
    output logic                    h75_g1,
    output logic                    h75_b1,
    output logic                    h75_r2,
    output logic                    h75_g2,
    output logic                    h75_b2,
    output logic [ROW_BITS-1:0]     h75_addr,
    output logic                    h75_clk,
    output logic                    h75_lat,
    output logic                    h75_oe_n,
    output logic                    frame_start
);

    localparam int PB     = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
    localparam int ON_MAX = BASE_ON << (COLOR_BITS - 1);
    localparam int M1     = (ON_MAX > CLK_DIV) ? ON_MAX : CLK_DIV;
    localparam int MAXC   = (M1 > BLANK_CYCLES) ? M1 : BLANK_CYCLES;
    localparam int CW     = $clog2(MAXC + 1);

    localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CB-1:0] COL_LAST   = CB'(COLS - 1);
    localparam logic [PB-1:0] PLANE_LAST = PB'(COLOR_BITS - 1);

    typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, DISPLAY} state_t;

    state_t              state, state_nx;
    logic [ROW_BITS-1:0] row, row_adv;
    logic [PB-1:0]       plane, plane_adv;
    logic [CW-1:0]       cnt, on_last;
    logic [CB-1:0]       col;
    logic                pre, hi;
    logic                div_end, last_col, shift_done, blank_done, disp_done, enter_shift;
    logic [COLOR_BITS-1:0] r0, g0, b0, r1, g1, b1;

    assign rd_row     = row;
    assign on_last    = (CW'(BASE_ON) << plane) - CW'(1);
    assign div_end    = (cnt == DIV_LAST);
    assign last_col   = (col == COL_LAST);
    assign shift_done = (state == SHIFT) && !pre && hi && div_end && last_col;
    assign blank_done = (state == BLANK) && (cnt == BLANK_LAST);
    assign disp_done  = (state == DISPLAY) && (cnt == on_last);
    assign enter_shift = enable && ((state == IDLE) || disp_done);
    assign plane_adv  = (plane == PLANE_LAST) ? '0 : plane + PB'(1);
    assign row_adv    = (plane == PLANE_LAST) ? row + ROW_BITS'(1) : row;

    assign {r0, g0, b0} = rd_rgb0;
    assign {r1, g1, b1} = rd_rgb1;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (enable) state_nx = SHIFT;
            SHIFT:   if (shift_done) state_nx = BLANK;
            BLANK:   if (blank_done) state_nx = LATCH;
            LATCH:   state_nx = DISPLAY;
            DISPLAY: if (disp_done) state_nx = enable ? SHIFT : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        h75_oe_n = (state != DISPLAY);
        h75_lat  = (state == LATCH);
        h75_clk  = (state == SHIFT) && !pre && hi;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row <= '0; plane <= '0; cnt <= '0; col <= '0; pre <= 1'b0; hi <= 1'b0;
            rd_col <= '0; h75_addr <= '0; frame_start <= 1'b0;
            {h75_r1, h75_g1, h75_b1, h75_r2, h75_g2, h75_b2} <= '0;
        end else begin
            frame_start <= 1'b0;
            if (state == IDLE && enable) begin
                row <= '0; plane <= '0;
            end else if (disp_done) begin
                row <= row_adv; plane <= plane_adv;
            end
            if (enter_shift) begin
                pre <= 1'b1; hi <= 1'b0; col <= '0; rd_col <= '0; cnt <= '0;
                frame_start <= (state == IDLE) || (row_adv == '0 && plane_adv == '0);
            end else begin
                case (state)
                    SHIFT: begin
                        // Data registers update only when a low phase begins, so they
                        // hold steady through the following high phase.
                        if (pre) begin
                            pre <= 1'b0;
                            {h75_r1, h75_g1, h75_b1} <= {r0[plane], g0[plane], b0[plane]};
                            {h75_r2, h75_g2, h75_b2} <= {r1[plane], g1[plane], b1[plane]};
                        end else if (div_end) begin
                            cnt <= '0;
                            hi  <= ~hi;
                            if (!hi && !last_col) rd_col <= col + CB'(1);
                            if (hi && !last_col) begin
                                col <= col + CB'(1);
                                {h75_r1, h75_g1, h75_b1} <= {r0[plane], g0[plane], b0[plane]};
                                {h75_r2, h75_g2, h75_b2} <= {r1[plane], g1[plane], b1[plane]};
                            end
                            if (hi && last_col) h75_addr <= row;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    BLANK:   cnt <= blank_done ? '0 : cnt + CW'(1);
                    DISPLAY: cnt <= disp_done ? '0 : cnt + CW'(1);
                    default: cnt <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hub75_bcm_scan.sv
// Directed bench for hub75_bcm_scan: pixel/address/on-time scoreboards plus a CLK_DIV=3 instance.
module tb_hub75_bcm_scan;

    localparam int RB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, enable, rst3, en3;
    logic [RB-1:0] rd_row, rd_row3, addr, addr3;
    logic [1:0] rd_col, rd_col3;
    logic [5:0] rgb0, rgb1, rgb0_3, rgb1_3;
    logic r1, g1, b1, r2, g2, b2, hclk, lat, oe_n, fs;
    logic q_r1, q_g1, q_b1, q_r2, q_g2, q_b2, hclk3, lat3, oe3, fs3;

    logic [5:0] mem0 [4][4];
    logic [5:0] mem1 [4][4];

    assign rgb0   = mem0[rd_row][rd_col];
    assign rgb1   = mem1[rd_row][rd_col];
    assign rgb0_3 = mem0[rd_row3][rd_col3];
    assign rgb1_3 = mem1[rd_row3][rd_col3];

    hub75_bcm_scan #(.COLS(4), .ROW_BITS(2), .COLOR_BITS(2), .CLK_DIV(1),
                     .BLANK_CYCLES(2), .BASE_ON(4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .rd_row(rd_row), .rd_col(rd_col),
        .rd_rgb0(rgb0), .rd_rgb1(rgb1),
        .h75_r1(r1), .h75_g1(g1), .h75_b1(b1), .h75_r2(r2), .h75_g2(g2), .h75_b2(b2),
        .h75_addr(addr), .h75_clk(hclk), .h75_lat(lat), .h75_oe_n(oe_n), .frame_start(fs));

    hub75_bcm_scan #(.COLS(4), .ROW_BITS(2), .COLOR_BITS(2), .CLK_DIV(3),
                     .BLANK_CYCLES(2), .BASE_ON(4)) dut3 (
        .clk(clk), .rst(rst3), .enable(en3), .rd_row(rd_row3), .rd_col(rd_col3),
        .rd_rgb0(rgb0_3), .rd_rgb1(rgb1_3),
        .h75_r1(q_r1), .h75_g1(q_g1), .h75_b1(q_b1), .h75_r2(q_r2), .h75_g2(q_g2), .h75_b2(q_b2),
        .h75_addr(addr3), .h75_clk(hclk3), .h75_lat(lat3), .h75_oe_n(oe3), .frame_start(fs3));

    int ncmp = 0, nerr = 0;
    logic [5:0]    px_q[$], px3_q[$];
    int            on_q[$];
    logic [RB-1:0] addr_q[$];
    int lat_cnt = 0, on_cnt = 0, fs_cnt = 0, rise3_cnt = 0, on3_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected {r1,g1,b1,r2,g2,b2} for one column of one bit-plane
    function automatic logic [5:0] exp_px(input int r, input int k, input int p);
        logic [5:0] a, b;
        a = mem0[r][k];
        b = mem1[r][k];
        return {a[4+p], a[2+p], a[p], b[4+p], b[2+p], b[p]};
    endfunction

    task automatic push_rp(input int r, input int p, input bit with_on);
        for (int k = 0; k < 4; k++) px_q.push_back(exp_px(r, k, p));
        addr_q.push_back(RB'(r));
        if (with_on) on_q.push_back(4 << p);
    endtask

    task automatic push3(input int r, input int p);
        for (int k = 0; k < 4; k++) px3_q.push_back(exp_px(r, k, p));
    endtask

    function automatic int sel(input int which);
        case (which)
            0: return on_cnt;
            1: return lat_cnt;
            2: return fs_cnt;
            3: return rise3_cnt;
            default: return on3_cnt;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int which, input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sel(which) >= target) break;
            @(negedge clk);
        end
        chk(tag, sel(which) >= target, 1);
    endtask

    // Monitor for the CLK_DIV=1 instance
    logic       pclk = 1'b0;
    int         run_len = 0;
    logic [RB-1:0] run_addr;
    logic       addr_moved = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            run_len = 0; addr_moved = 1'b0; pclk = 1'b0;
        end else begin
            if (hclk && !pclk) begin
                chk("px_avail", px_q.size() != 0, 1);
                if (px_q.size() != 0) chk("pixel", {r1, g1, b1, r2, g2, b2}, px_q.pop_front());
            end
            if (lat) begin
                lat_cnt++;
                chk("addr_avail", addr_q.size() != 0, 1);
                if (addr_q.size() != 0) chk("latch_addr", addr, addr_q.pop_front());
            end
            if (!oe_n) begin
                if (run_len == 0) run_addr = addr;
                else if (addr != run_addr) addr_moved = 1'b1;
                run_len++;
            end else if (run_len != 0) begin
                chk("on_avail", on_q.size() != 0, 1);
                if (on_q.size() != 0) chk("on_len", run_len, on_q.pop_front());
                chk("addr_stable_on", addr_moved, 0);
                on_cnt++;
                run_len = 0; addr_moved = 1'b0;
            end
            if (fs) fs_cnt++;
            pclk = hclk;
        end
    end

    // Monitor for the CLK_DIV=3 instance: phase lengths and data stability
    logic p3 = 1'b0, poe3 = 1'b1;
    int   hi_len = 0, lo_len = 0;
    logic [5:0] hi_data;
    always @(negedge clk) begin
        if (rst3) begin
            p3 = 1'b0; poe3 = 1'b1; hi_len = 0; lo_len = 0;
        end else begin
            if (hclk3 && !p3) begin
                if (rise3_cnt % 4 != 0) chk("div3_lo_len", lo_len, 3);
                chk("px3_avail", px3_q.size() != 0, 1);
                if (px3_q.size() != 0) chk("pixel3", {q_r1, q_g1, q_b1, q_r2, q_g2, q_b2}, px3_q.pop_front());
                hi_data = {q_r1, q_g1, q_b1, q_r2, q_g2, q_b2};
                hi_len = 1;
                rise3_cnt++;
            end else if (hclk3 && p3) begin
                hi_len++;
                chk("div3_hi_stable", {q_r1, q_g1, q_b1, q_r2, q_g2, q_b2}, hi_data);
            end else if (!hclk3 && p3) begin
                chk("div3_hi_len", hi_len, 3);
                lo_len = 1;
            end else begin
                lo_len++;
            end
            if (oe3 && !poe3) on3_cnt++;
            p3 = hclk3;
            poe3 = oe3;
        end
    end

    initial begin
        int lows;
        rst = 1'b1; enable = 1'b1; rst3 = 1'b1; en3 = 1'b0;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) begin
                mem0[r][k] = (r == 0) ? 6'h3F : 6'($urandom_range(0, 63));
                mem1[r][k] = (r == 0) ? 6'h00 : 6'($urandom_range(0, 63));
            end
        mem0[0][2] = 6'b10_11_11;  // R=2'b10 at column 2 of row 0

        repeat (3) @(negedge clk);
        chk("rst_oe_n", oe_n, 1);
        chk("rst_lat", lat, 0);
        chk("rst_hclk", hclk, 0);
        chk("rst_addr", addr, 0);
        chk("rst_rd_row", rd_row, 0);
        chk("rst_rd_col", rd_col, 0);
        chk("rst_fs", fs, 0);
        chk("rst_data", {r1, g1, b1, r2, g2, b2}, 0);

        // Full frame plus row 0 (both planes) and row 1 plane 0 of the next
        for (int i = 0; i < 11; i++) push_rp((i / 2) % 4, i % 2, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        chk("fs_cycle1", fs, 1);
        chk("prefetch_col", rd_col, 0);
        chk("shift_oe_n", oe_n, 1);
        @(negedge clk);
        chk("fs_one_clk", fs, 0);

        wait_for("wait_rp10", 0, 10, 1000);
        repeat (3) @(negedge clk);
        chk("mid_shift_row", rd_row, 1);
        chk("mid_shift_oe_n", oe_n, 1);
        enable = 1'b0;
        wait_for("wait_rp11", 0, 11, 200);
        chk("fs_per_frame", fs_cnt, 2);

        lows = 0;
        repeat (20) begin
            @(negedge clk);
            if (!oe_n) lows++;
        end
        chk("idle_oe_low", lows, 0);
        chk("idle_lat_cnt", lat_cnt, 11);
        chk("px_q_drained", px_q.size(), 0);
        chk("on_q_drained", on_q.size(), 0);

        // Re-enable, then reset in the middle of the display window
        push_rp(0, 0, 1'b0);
        enable = 1'b1;
        wait_for("wait_fs_reen", 2, 3, 10);
        wait_for("wait_lat_reen", 1, 12, 100);
        @(negedge clk);
        @(negedge clk);
        chk("in_display", oe_n, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rstd_oe_n", oe_n, 1);
        chk("rstd_lat", lat, 0);
        chk("rstd_hclk", hclk, 0);
        chk("rstd_addr", addr, 0);

        push_rp(0, 0, 1'b1);
        push_rp(0, 1, 1'b1);
        rst = 1'b0;
        wait_for("wait_fs_rst", 2, 4, 10);
        wait_for("wait_rp12", 0, 12, 200);
        enable = 1'b0;
        wait_for("wait_rp13", 0, 13, 200);
        repeat (5) @(negedge clk);
        chk("stop_oe_n", oe_n, 1);
        chk("fs_total", fs_cnt, 4);
        chk("lat_total", lat_cnt, 14);
        chk("px_q_end", px_q.size(), 0);
        chk("addr_q_end", addr_q.size(), 0);
        chk("on_q_end", on_q.size(), 0);

        // CLK_DIV=3 instance: two row-planes then stop
        push3(0, 0);
        push3(0, 1);
        rst3 = 1'b0;
        en3 = 1'b1;
        wait_for("wait_rise3", 3, 5, 400);
        en3 = 1'b0;
        wait_for("wait_on3", 4, 2, 400);
        repeat (3) @(negedge clk);
        chk("px3_q_end", px3_q.size(), 0);
        chk("oe3_idle", oe3, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
